// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down trace decoder: FSM states,
// step codes produced by the classifier, and default widths.
package updown_pkg;

  typedef enum logic [2:0] {
    PRIME,
    HOLD,
    UP,
    DOWN,
    ERROR
  } state_t;

  localparam logic [1:0] STEP_UP   = 2'd0;
  localparam logic [1:0] STEP_DN   = 2'd1;
  localparam logic [1:0] STEP_HOLD = 2'd2;
  localparam logic [1:0] STEP_BAD  = 2'd3;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_RUN_W = 4;

endpackage

// File: rtl/updown_step_classify.sv
// Combinational classifier: maps (prev, count) to a step code.
// Define UPDOWN_TRACE_WRAP_EN to accept MAX->0 as up and 0->MAX as down.
module updown_step_classify
  import updown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count,
  output logic [1:0]       step
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] delta;
  logic             wrap_step;

  assign delta = count - prev;

`ifdef UPDOWN_TRACE_WRAP_EN
  assign wrap_step = 1'b0;
`else
  // A saturating counter never wraps, so modular +/-1 across the rails is illegal.
  assign wrap_step = ((prev == MAX) && (count == '0)) ||
                     ((prev == '0) && (count == MAX));
`endif

  always_comb begin
    step = STEP_BAD;
    if (wrap_step)
      step = STEP_BAD;
    else if (delta == '0)
      step = STEP_HOLD;
    else if (delta == ONE)
      step = STEP_UP;
    else if (delta == MAX)
      step = STEP_DN;
  end

endmodule

// File: rtl/updown_trace_decoder.sv
// Observer for a saturating up/down counter: rebuilds en/dir per sample,
// flags rail saturation and illegal jumps, tracks run length.
// UPDOWN_TRACE_WRAP_EN (in the classifier) makes rail-to-rail wraps legal steps.
module updown_trace_decoder
  import updown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUN_W = DEF_RUN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count,
  output logic             valid_o,
  output logic             en_o,
  output logic             dir_o,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             err,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [1:0]       step;
  logic [RUN_W-1:0] run_inc;
  logic             continue_up;
  logic             continue_dn;

  updown_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev  (prev),
    .count (count),
    .step  (step)
  );

  assign run_inc = (run_len == RUN_MAX) ? run_len : run_len + RUN_ONE;

  // A hold does not break a run: dir_o still remembers the last moving direction.
  assign continue_up = (state == UP)   || ((state == HOLD) &&  dir_o);
  assign continue_dn = (state == DOWN) || ((state == HOLD) && !dir_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PRIME;
      prev    <= '0;
      valid_o <= 1'b0;
      en_o    <= 1'b0;
      dir_o   <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
      err     <= 1'b0;
      run_len <= '0;
    end else begin
      valid_o <= 1'b0;
      if (sample_valid) begin
        prev   <= count;
        sat_hi <= (count == MAX);
        sat_lo <= (count == '0);
        if (state == PRIME) begin
          state <= HOLD;
        end else begin
          valid_o <= 1'b1;
          case (step)
            STEP_UP: begin
              en_o    <= 1'b1;
              dir_o   <= 1'b1;
              state   <= UP;
              run_len <= continue_up ? run_inc : RUN_ONE;
            end
            STEP_DN: begin
              en_o    <= 1'b1;
              dir_o   <= 1'b0;
              state   <= DOWN;
              run_len <= continue_dn ? run_inc : RUN_ONE;
            end
            STEP_HOLD: begin
              en_o  <= 1'b0;
              state <= HOLD;
            end
            default: begin
              en_o  <= 1'b0;
              err   <= 1'b1;
              state <= ERROR;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_trace_decoder.sv
// Directed self-checking bench for updown_trace_decoder; expectations are
// hand-computed, with the wrap case following UPDOWN_TRACE_WRAP_EN.
module tb_updown_trace_decoder;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [2:0] count;
  logic       valid_o;
  logic       en_o;
  logic       dir_o;
  logic       sat_hi;
  logic       sat_lo;
  logic       err;
  logic [3:0] run_len;

  int checks;
  int failures;

  updown_trace_decoder #(.WIDTH(3), .RUN_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .count        (count),
    .valid_o      (valid_o),
    .en_o         (en_o),
    .dir_o        (dir_o),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo),
    .err          (err),
    .run_len      (run_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one sample (held until the next call), then samples #1 after the edge.
  task automatic applyStimulus(input logic [2:0] v);
    sample_valid = 1'b1;
    count        = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int v, input int e, input int d,
                          input int hi, input int lo, input int er, input int rl);
    checkOutput({tag, ".valid"},   int'(valid_o), v);
    checkOutput({tag, ".en"},      int'(en_o),    e);
    checkOutput({tag, ".dir"},     int'(dir_o),   d);
    checkOutput({tag, ".sat_hi"},  int'(sat_hi),  hi);
    checkOutput({tag, ".sat_lo"},  int'(sat_lo),  lo);
    checkOutput({tag, ".err"},     int'(err),     er);
    checkOutput({tag, ".run_len"}, int'(run_len), rl);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    count        = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Full up ramp 0..7 then a saturated hold at 7
    applyStimulus(3'd0);
    checkAll("t1.prime", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(3'(i));
      checkAll($sformatf("t1.up%0d", i), 1, 1, 1, int'(i == 7), 0, 0, i);
    end
    applyStimulus(3'd7);
    checkAll("t1.hold7", 1, 0, 1, 1, 0, 0, 7);

    // Full down ramp back to 0 then a saturated hold at 0
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(3'(i));
      checkAll($sformatf("t2.dn%0d", i), 1, 1, 0, 0, int'(i == 0), 0, 7 - i);
    end
    applyStimulus(3'd0);
    checkAll("t2.hold0", 1, 0, 0, 0, 1, 0, 7);
    idleCycle();
    checkOutput("t2.idle.valid", int'(valid_o), 0);

    // Hold in the middle of an up run keeps dir and resumes the run
    doReset();
    applyStimulus(3'd2);
    checkAll("t3.prime", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(3'd3);
    checkAll("t3.up", 1, 1, 1, 0, 0, 0, 1);
    applyStimulus(3'd3);
    checkAll("t3.hold", 1, 0, 1, 0, 0, 0, 1);
    applyStimulus(3'd4);
    checkAll("t3.resume", 1, 1, 1, 0, 0, 0, 2);

    // Illegal jump is sticky; legal steps still decode; reset clears it
    doReset();
    applyStimulus(3'd2);
    applyStimulus(3'd5);
    checkAll("t4.jump", 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(3'd6);
    checkAll("t4.after", 1, 1, 1, 0, 0, 1, 1);
    doReset();
    checkAll("t4.reset", 0, 0, 0, 0, 0, 0, 0);

    // Rail-to-rail wrap in both directions
    applyStimulus(3'd7);
    checkAll("t5.prime", 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(3'd0);
`ifdef UPDOWN_TRACE_WRAP_EN
    checkAll("t5.wrapup", 1, 1, 1, 0, 1, 0, 1);
`else
    checkAll("t5.wrapup", 1, 0, 0, 0, 1, 1, 0);
`endif
    applyStimulus(3'd7);
`ifdef UPDOWN_TRACE_WRAP_EN
    checkAll("t5.wrapdn", 1, 1, 0, 1, 0, 0, 1);
`else
    checkAll("t5.wrapdn", 1, 0, 0, 1, 0, 1, 0);
`endif

    // Reset coinciding with a sample wins and re-enters PRIME
    doReset();
    applyStimulus(3'd3);
    applyStimulus(3'd4);
    checkAll("t6.up", 1, 1, 1, 0, 0, 0, 1);
    rst          = 1'b1;
    sample_valid = 1'b1;
    count        = 3'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("t6.rst", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(3'd5);
    checkAll("t6.prime", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(3'd6);
    checkAll("t6.up2", 1, 1, 1, 0, 0, 0, 1);
    idleCycle();
    checkOutput("t6.idle.valid", int'(valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_trace_decoder.md
Name: updown_trace_decoder

Overview:
Reader-side companion to the team's saturating up/down counter. It samples the counter's count bus and reconstructs, per sample, the step that produced it: up, down or hold. It also flags saturation at either rail and illegal jumps, and tracks run length. It sits on the monitor/observer side of any counter instance, in hardware checkers or as a debug probe.

Parameters:
WIDTH, 3, width of the observed count bus; MAX = 2^WIDTH-1
RUN_W, 4, width of run-length counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
sample_valid  input  1  count is a new sample this cycle
count  input  WIDTH  observed counter value
valid_o  output  1  one-cycle strobe: decoded step fields are valid
en_o  output  1  decoded enable (1 = count moved)
dir_o  output  1  decoded direction (1 = up, 0 = down); holds last moving direction on hold
sat_hi  output  1  last accepted sample == MAX
sat_lo  output  1  last accepted sample == 0
err  output  1  sticky illegal-transition flag
run_len  output  RUN_W  consecutive steps in the same direction, including the current step

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a rising edge: state=PRIME, prev=0, and all outputs 0 (valid_o, en_o, dir_o, sat_hi, sat_lo, err, run_len). rst has priority over sample_valid. Reset mid-run discards history, including err.
- States: PRIME, HOLD, UP, DOWN, ERROR.
- PRIME: first sample_valid latches prev=count and updates sat_hi/sat_lo. valid_o stays 0. Next state is HOLD.
- Decode in HOLD/UP/DOWN on sample_valid, with delta = count - prev computed mod 2^WIDTH:
  - delta=+1 -> en_o=1, dir_o=1, next UP.
  - delta=-1 (all ones) -> en_o=1, dir_o=0, next DOWN.
  - delta=0 -> en_o=0, dir_o unchanged, next HOLD. Covers both en=0 and a saturated step; sat_hi/sat_lo disambiguate.
  - any other delta, including the wrap MAX->0 and 0->MAX -> err<=1, en_o=0, next ERROR.
- Output timing: valid_o=1 for exactly one cycle, in the cycle after each decoded sample_valid (registered, latency 1). valid_o=0 when sample_valid=0. prev<=count on every accepted sample.
- sat_hi/sat_lo: registered from the accepted sample; both update even in ERROR.
- run_len:
  - Entering UP from non-UP, or DOWN from non-DOWN -> 1.
  - Same direction repeated -> +1, saturating at 2^RUN_W-1 (no wrap).
  - HOLD -> unchanged; the run resumes if the next step continues the same direction.
  - Opposite direction -> restarts at 1.
- ERROR: valid_o still strobes with en_o=0. prev keeps tracking count, and err stays 1 until rst. Decoding of subsequent legal deltas continues; state leaves ERROR per the normal rules, but err never clears.
- Back-to-back sample_valid every cycle is supported with no bubbles.

Optional Feature:
UPDOWN_TRACE_WRAP_EN
- Defined: MAX->0 decodes as up and 0->MAX as down, with no err. Supports a wrapping counter variant. These transitions still set sat_lo/sat_hi from the sample value.
- Undefined: both wraps are illegal and set err (default, matches the saturating counter).

Decomposition:
- Shared package updown_pkg holds:
  - state enum (PRIME, HOLD, UP, DOWN, ERROR);
  - step-code localparams STEP_UP, STEP_DN, STEP_HOLD, STEP_BAD;
  - default WIDTH and RUN_W.
- One natural sub-module, updown_step_classify: combinational prev/count -> step code. Its wrap handling is gated by the macro. Everything sequential stays in the top.

Test Plan:
1. rst=1 for 1 cycle, then samples 0,1,2,...,7,7 -> first sample gives no valid_o. Then seven strobes with en_o=1, dir_o=1, and run_len 1..7. Final sample: en_o=0, sat_hi=1, run_len=7, err=0.
2. From 7, samples 6,5,...,0,0 -> en_o=1, dir_o=0, run_len restarts at 1 and reaches 7. Last strobe: en_o=0, sat_lo=1.
3. Samples 3,3,4 -> hold then up. dir_o is kept through the hold, and run_len continues from the prior up run.
4. Samples 2,5 -> err=1, en_o=0. Then 6 -> en_o=1, dir_o=1, err still 1. Then rst=1 -> err=0, valid_o=0.
5. Samples 7,0 -> err=1 without the macro. With UPDOWN_TRACE_WRAP_EN: en_o=1, dir_o=1, sat_lo=1, err=0.
6. rst asserted together with sample_valid mid-run -> reset wins. The next sample is PRIME: no valid_o, and run_len=0.
